sdram_test_sequencer: RTL

- Drives the byte-wide user port of the SDRAM controller on the board test design.
- Runs two passes over a configurable address range:
  - write pass: writes an address-derived pattern to every location;
  - read pass: reads each location back and compares it to the expected pattern.
- Reports pass/fail, a fault count, the first failing address and a finished flag to the LEDs and the on-chip debug probes.
- Sits between the top level and the SDRAM controller, in the controller's user clock domain.

---
 rtl/sdram_test_sequencer.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/sdram_test_sequencer.sv
// Write-then-read-back pattern test over an address range on the SDRAM controller user port.
// Reports compare result, fault count, first failing address and completion to LEDs/probes.
module sdram_test_sequencer #(
    parameter int unsigned       ADDR_W     = 27,
    parameter int unsigned       DATA_W     = 8,
    parameter logic [ADDR_W-1:0] START_ADDR = '0,
    parameter logic [ADDR_W-1:0] END_ADDR   = '1,
    parameter logic [7:0]        SEED       = 8'hA5,
    parameter int unsigned       RD_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] sdram_address,
    output logic [DATA_W-1:0] sdram_din,
    output logic              sdram_write,
    output logic              sdram_read,
    input  logic              sdram_busy,
    input  logic              sdram_data_ready,
    input  logic [DATA_W-1:0] sdram_dout,
    output logic              data_correct,
    output logic              scan_finished,
    output logic              led_succeed,
    output logic              led_fault,
    output logic [15:0]       fault_count,
    output logic [ADDR_W-1:0] first_fault_addr
);
    localparam int unsigned TW = $clog2(RD_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic              guard;
    logic [TW-1:0]     tmo;
    logic [DATA_W-1:0] exp_data;
    logic              at_end;
    logic              rd_timeout;
    logic              rd_mismatch;
    logic              fault;

    function automatic logic [DATA_W-1:0] pat(input logic [15:0] a);
        logic [7:0] p;
        p = a[7:0] ^ a[15:8] ^ SEED;
        return DATA_W'(p);
    endfunction

    always_comb begin
        exp_data    = pat(addr[15:0]);
        at_end      = (addr == END_ADDR);
        rd_timeout  = !sdram_data_ready && (tmo == TW'(RD_TIMEOUT - 1));
        rd_mismatch = sdram_data_ready && (sdram_dout != exp_data);
        fault       = (state == RD_WAIT) && (rd_mismatch || rd_timeout);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            addr             <= '0;
            guard            <= 1'b0;
            tmo              <= '0;
            sdram_address    <= '0;
            sdram_din        <= '0;
            sdram_write      <= 1'b0;
            sdram_read       <= 1'b0;
            data_correct     <= 1'b1;
            scan_finished    <= 1'b0;
            led_succeed      <= 1'b0;
            led_fault        <= 1'b0;
            fault_count      <= '0;
            first_fault_addr <= '0;
        end else begin
            sdram_write <= 1'b0;
            sdram_read  <= 1'b0;

            if (fault) begin
                if (fault_count == '0)
                    first_fault_addr <= addr;
                if (fault_count != '1)
                    fault_count <= fault_count + 16'd1;
                led_fault <= 1'b1;
            end

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        addr             <= START_ADDR;
                        fault_count      <= '0;
                        first_fault_addr <= '0;
                        led_fault        <= 1'b0;
                        led_succeed      <= 1'b0;
                        scan_finished    <= 1'b0;
                        data_correct     <= 1'b1;
                        state            <= WR_ISSUE;
                    end
                end
                WR_ISSUE: begin
                    if (!sdram_busy) begin
                        sdram_write   <= 1'b1;
                        sdram_address <= addr;
                        sdram_din     <= exp_data;
                        guard         <= 1'b1;
                        state         <= WR_WAIT;
                    end
                end
                WR_WAIT: begin
                    // The controller raises busy a cycle late, so the first cycle here ignores it.
                    if (guard) begin
                        guard <= 1'b0;
                    end else if (!sdram_busy) begin
                        if (at_end) begin
                            addr  <= START_ADDR;
                            state <= RD_ISSUE;
                        end else begin
                            addr  <= addr + ADDR_W'(1);
                            state <= WR_ISSUE;
                        end
                    end
                end
                RD_ISSUE: begin
                    if (!sdram_busy) begin
                        sdram_read    <= 1'b1;
                        sdram_address <= addr;
                        tmo           <= '0;
                        state         <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (sdram_data_ready || rd_timeout) begin
                        data_correct <= !(rd_mismatch || rd_timeout);
                        if (at_end) begin
                            // A fault on the last address is counted this same cycle.
                            led_succeed   <= (fault_count == '0) && !fault;
                            scan_finished <= 1'b1;
                            state         <= DONE;
                        end else begin
                            addr  <= addr + ADDR_W'(1);
                            state <= RD_ISSUE;
                        end
                    end else begin
                        tmo <= tmo + TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
